ysyx_25060170_ex_mdu: RTL and testbench
=======================================

# ysyx_25060170_ex_mdu

Iterative RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (`ex_inst`, `ex_op1`, `ex_op2`, `ex_rd_addr`). It accepts one M-extension instruction at a time and computes the result over multiple cycles. While computing, it holds the ID/EX register through its `ex_ready` stall input. It returns a registered 32-bit result with a one-cycle valid pulse to the EX result mux.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports:
- `clk` in 1 — clock, all state updates on posedge
- `rst` in 1 — synchronous, active-high reset
- `ex_inst` in 32 — instruction in EX; M-op when opcode=0110011 and funct7=0000001; funct3 selects op
- `ex_op1` in 32 — rs1 value (multiplicand/dividend)
- `ex_op2` in 32 — rs2 value (multiplier/divisor)
- `ex_rd_addr` in 5 — destination register
- `ex_flush` in 1 — kill in-flight op (OR of id/ie/ls flush)
- `mdu_busy` out 1 — high = hold ID/EX; wired to ID/EX `ex_ready`
- `mdu_valid` out 1 — one-cycle result pulse
- `mdu_result` out 32 — result, meaningful when `mdu_valid`
- `mdu_rd_addr` out 5 — rd of the result

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - accept when `is_mop & ~ex_flush`; latch |op1|, |op2|, result-sign, rem-sign, funct3, rd.
  - Special cases go IDLE→DONE with the result precomputed:
    - div-by-zero: DIV/DIVU → 0xFFFFFFFF, REM/REMU → op1.
    - signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0.
  - All other ops go IDLE→CALC with `cnt`=0.
- CALC:
  - one radix-2 step per cycle: shift-add multiply (64-bit accumulator) or restoring divide (33-bit partial remainder).
  - `cnt` increments; after step 31 (`cnt`==31) go to DONE.
  - Final sign correction (two's-complement negate) is applied on the CALC→DONE edge.
- DONE: `mdu_valid=~ex_flush`; unconditionally go to IDLE next edge.
- Sign rules:
  - MULH: signed×signed.
  - MULHSU: signed×unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - MUL returns product[31:0]; MULH* return product[63:32].
- `mdu_busy = (IDLE & is_mop) | CALC`. It is combinational so ID/EX holds from the accept cycle onward. It is low in DONE so ID/EX advances on that edge.
- `ex_flush` in any state → IDLE next edge; result discarded, no `mdu_valid`. Flush takes priority over accept.
- Reset (including mid-operation) → IDLE. All outputs 0: `mdu_busy`=0 only once `rst` is low and no M-op is present, `mdu_valid`=0, `mdu_result`=0, `mdu_rd_addr`=0.
- Non-M instructions: no effect; `mdu_busy`=0.

## Timing
- Accept in cycle T.
- Iterative op: CALC for cycles T+1..T+32, `mdu_valid` at T+33 (33-cycle latency).
- Special case: `mdu_valid` at T+1.
- Back-to-back: a new op is accepted no earlier than the cycle after DONE (T+34).
- `mdu_result` and `mdu_rd_addr` hold their value after DONE until the next completion.

## Configuration
- `YSYX_25060170_MUL_FAST_EN` defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33×33 signed multiplier and go IDLE→DONE (`mdu_valid` at T+1).
  - Divide is unchanged.
- Undefined: multiplies use the 32-cycle shift-add path. No hardware multiplier is synthesized.

## Structure
- In `define.v`:
  - state encodings `ysyx_25060170_MDU_IDLE/CALC/DONE`.
  - funct3 codes `ysyx_25060170_F3_MUL..REMU`.
  - M-op opcode/funct7 constants.
- Sub-module `ysyx_25060170_div_step`: combinational single restoring-divide step (partial remainder, divisor → next remainder, quotient bit). The main block registers it.

## Test plan
- MUL 7 × 0xFFFFFFFD, accept T (non-fast) → `mdu_busy` high T..T+32, `mdu_valid` at T+33 with 0xFFFFFFEB, rd echoed.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; all at T+33.
- DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0.
- DIV accepted at T, `ex_flush` at T+10 → IDLE at T+11, no `mdu_valid`. A new MUL presented at T+11 is accepted and completes at T+44.
- `rst` asserted at T+5 of a DIV → all outputs 0 next cycle. With `YSYX_25060170_MUL_FAST_EN`, MUL 3×4 → 12 at T+1.

Source files
------------

// File: rtl/ysyx_25060170_ex_mdu_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: FSM states,
// M-extension decode fields and funct3 operation codes.
package ysyx_25060170_ex_mdu_pkg;

  typedef enum logic [1:0] {
    MduIdle = 2'd0,
    MduCalc = 2'd1,
    MduDone = 2'd2
  } mdu_state_e;

  localparam logic [6:0] OpcodeOp     = 7'b0110011;
  localparam logic [6:0] Funct7MulDiv = 7'b0000001;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ysyx_25060170_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module ysyx_25060170_div_step (
  input  logic [31:0] rem_in,
  input  logic        dividend_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        q_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // rem_in < divisor, so the 33-bit shifted value never overflows and a
  // set diff[32] means the trial subtraction went negative.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[32];
    rem_out = q_bit ? diff[31:0] : shifted[31:0];
  end

endmodule

// File: rtl/ysyx_25060170_ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage. Holds ID/EX via
// mdu_busy while computing and emits a one-cycle mdu_valid with the result.
// Define YSYX_25060170_MUL_FAST_EN to complete multiplies in a single cycle
// with a 33x33 signed multiplier; otherwise multiplies use 32 shift-add steps.
module ysyx_25060170_ex_mdu
  import ysyx_25060170_ex_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ex_inst,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [4:0]      ex_rd_addr,
  input  logic            ex_flush,
  output logic            mdu_busy,
  output logic            mdu_valid,
  output logic [XLEN-1:0] mdu_result,
  output logic [4:0]      mdu_rd_addr
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;        // mul: {partial product, multiplier}; div: {remainder, dividend}
  logic [31:0] opnd_q, opnd_d;      // mul: multiplicand; div: divisor
  logic [2:0]  f3_q, f3_d;
  logic        neg_q, neg_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  logic [2:0]  f3;
  logic        is_mop;
  logic        op1_signed, op2_signed, s1, s2;
  logic [31:0] abs1, abs2;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;
  logic        inst_unused;

  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_fix;
  logic [31:0] div_rem;
  logic        div_q;
  logic [63:0] div_next;
  logic [31:0] calc_res;

  assign f3          = ex_inst[14:12];
  assign is_mop      = (ex_inst[6:0] == OpcodeOp) && (ex_inst[31:25] == Funct7MulDiv);
  assign inst_unused = ^{ex_inst[24:15], ex_inst[11:7]};

  // Decode operand signedness, magnitudes and the precomputed special cases.
  always_comb begin
    op1_signed = (f3 == F3Mulh) || (f3 == F3Mulhsu) || (f3 == F3Div) || (f3 == F3Rem);
    op2_signed = (f3 == F3Mulh) || (f3 == F3Div) || (f3 == F3Rem);
    s1         = op1_signed & ex_op1[31];
    s2         = op2_signed & ex_op2[31];
    abs1       = neg_if(s1, ex_op1);
    abs2       = neg_if(s2, ex_op2);
    div_zero   = f3[2] && (ex_op2 == 32'd0);
    div_ovf    = ((f3 == F3Div) || (f3 == F3Rem)) &&
                 (ex_op1 == 32'h8000_0000) && (ex_op2 == 32'hFFFF_FFFF);
    if (div_zero) special_res = f3[1] ? ex_op1 : 32'hFFFF_FFFF;
    else          special_res = f3[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef YSYX_25060170_MUL_FAST_EN
  logic signed [32:0] fm_a, fm_b;
  logic signed [65:0] fm_p;
  logic [31:0]        fast_res;
  logic               fm_unused;

  // Single-cycle multiply; the 33rd bit carries each operand's sign extension.
  always_comb begin
    fm_a     = {s1, ex_op1};
    fm_b     = {s2, ex_op2};
    fm_p     = fm_a * fm_b;
    fast_res = (f3 == F3Mul) ? fm_p[31:0] : fm_p[63:32];
  end
  assign fm_unused = ^fm_p[65:64];
`endif

  ysyx_25060170_div_step u_div_step (
    .rem_in       (acc_q[63:32]),
    .dividend_bit (acc_q[31]),
    .divisor      (opnd_q),
    .rem_out      (div_rem),
    .q_bit        (div_q)
  );

  // One iteration of shift-add multiply or restoring divide, plus the final
  // sign-corrected result taken from the last iteration's output.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    mul_fix  = neg_q ? (~mul_next + 64'd1) : mul_next;
    div_next = {div_rem, acc_q[30:0], div_q};
    if (f3_q[2]) calc_res = neg_if(neg_q, f3_q[1] ? div_rem : div_next[31:0]);
    else         calc_res = (f3_q == F3Mul) ? mul_fix[31:0] : mul_fix[63:32];
  end

  // Next-state logic: accept, iterate, finish; flush always returns to idle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    unique case (state_q)
      MduIdle: begin
        if (is_mop && !ex_flush) begin
          f3_d  = f3;
          neg_d = (f3 == F3Rem) ? s1 : (s1 ^ s2);
          rd_d  = ex_rd_addr;
          cnt_d = 5'd0;
          if (div_zero || div_ovf) begin
            state_d  = MduDone;
            result_d = special_res;
            rd_out_d = ex_rd_addr;
          end
`ifdef YSYX_25060170_MUL_FAST_EN
          else if (!f3[2]) begin
            state_d  = MduDone;
            result_d = fast_res;
            rd_out_d = ex_rd_addr;
          end
`endif
          else begin
            state_d = MduCalc;
            acc_d   = {32'd0, f3[2] ? abs1 : abs2};
            opnd_d  = f3[2] ? abs2 : abs1;
          end
        end
      end
      MduCalc: begin
        if (ex_flush) begin
          state_d = MduIdle;
        end else begin
          acc_d = f3_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = MduDone;
            result_d = calc_res;
            rd_out_d = rd_q;
          end
        end
      end
      MduDone: state_d = MduIdle;
      default: state_d = MduIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MduIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      f3_q     <= 3'd0;
      neg_q    <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= 32'd0;
      rd_out_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // Busy is combinational so ID/EX freezes from the accept cycle onward.
  always_comb begin
    mdu_busy    = ((state_q == MduIdle) && is_mop) || (state_q == MduCalc);
    mdu_valid   = (state_q == MduDone) && !ex_flush;
    mdu_result  = result_q;
    mdu_rd_addr = rd_out_q;
  end

endmodule

// File: tb/tb_ysyx_25060170_ex_mdu.sv
// Self-checking bench for ysyx_25060170_ex_mdu: directed vectors with literal
// results plus randomized operations checked against a plain-arithmetic model.
module tb_ysyx_25060170_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_inst, ex_op1, ex_op2;
  logic [4:0]  ex_rd_addr;
  logic        ex_flush;
  logic        mdu_busy, mdu_valid;
  logic [31:0] mdu_result;
  logic [4:0]  mdu_rd_addr;

  always #5 clk = ~clk;

  ysyx_25060170_ex_mdu #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_inst     (ex_inst),
    .ex_op1      (ex_op1),
    .ex_op2      (ex_op2),
    .ex_rd_addr  (ex_rd_addr),
    .ex_flush    (ex_flush),
    .mdu_busy    (mdu_busy),
    .mdu_valid   (mdu_valid),
    .mdu_result  (mdu_result),
    .mdu_rd_addr (mdu_rd_addr)
  );

  int          checks = 0;
  int          errors = 0;
  logic        chk_on = 1'b0;
  logic        exp_busy, exp_valid;
  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  logic        lit_en = 1'b0;
  logic [31:0] lit_val;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Compare every cycle, mid-way between active edges.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("busy", {31'd0, mdu_busy}, {31'd0, exp_busy});
      cmp("valid", {31'd0, mdu_valid}, {31'd0, exp_valid});
      cmp("result", mdu_result, exp_res);
      cmp("rd", {27'd0, mdu_rd_addr}, {27'd0, exp_rd});
      if (lit_en) cmp("literal_result", mdu_result, lit_val);
    end
  end

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] non_m_inst();
    logic [31:0] r;
    r = $urandom;
    if (r[6:0] == 7'b0110011 && r[31:25] == 7'b0000001) r[25] = 1'b0;
    return r;
  endfunction

  // Reference result from RV32M semantics using native wide arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef YSYX_25060170_MUL_FAST_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_inst   = non_m_inst();
    ex_op1    = $urandom;
    ex_op2    = $urandom;
    ex_flush  = 1'b0;
    exp_busy  = 1'b0;
    exp_valid = 1'b0;
    lit_en    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_idle();
      step();
    end
    set_idle();
  endtask

  // Present one M-op held by the stall; optionally flush or reset at cycle k.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int flush_at, input int rst_at,
                       input logic has_lit, input logic [31:0] lit);
    int          lat;
    logic [31:0] r;
    lat        = latency(f3, a, b);
    r          = ref_res(f3, a, b);
    ex_inst    = mk_inst(f3, rd);
    ex_op1     = a;
    ex_op2     = b;
    ex_rd_addr = rd;
    ex_flush   = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        exp_busy  = 1'b0;
        exp_valid = 1'b1;
        exp_res   = r;
        exp_rd    = rd;
        lit_en    = has_lit;
        lit_val   = lit;
      end else begin
        exp_busy  = 1'b1;
        exp_valid = 1'b0;
      end
      if (c == flush_at) ex_flush = 1'b1;
      if (c == rst_at) rst = 1'b1;
      step();
      if (c == flush_at || c == rst_at) begin
        if (c == rst_at) begin
          rst     = 1'b0;
          exp_res = 32'd0;
          exp_rd  = 5'd0;
        end
        set_idle();
        return;
      end
    end
    set_idle();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lit;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst        = 1'b1;
    ex_inst    = 32'd0;
    ex_op1     = 32'd0;
    ex_op2     = 32'd0;
    ex_rd_addr = 5'd0;
    ex_flush   = 1'b0;
    exp_res    = 32'd0;
    exp_rd     = 5'd0;
    step();
    step();
    rst    = 1'b0;
    set_idle();
    chk_on = 1'b1;
    idle(3);

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{3'd1, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2});
    vecs.push_back('{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'd5,          32'd0,         32'd5});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{3'd0, 32'd3,          32'd4,         32'd12});

    foreach (vecs[i]) begin
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), -1, -1, 1'b1, vecs[i].lit);
      idle(1);
    end

    // An M-op with flush in idle is not accepted.
    ex_inst  = mk_inst(3'd4, 5'd9);
    ex_flush = 1'b1;
    exp_busy = 1'b1;
    step();
    idle(2);

    // Flush mid-divide, then a multiply presented the very next cycle.
    do_op(3'd4, 32'd1000, 32'd3, 5'd20, 10, -1, 1'b0, 32'd0);
    do_op(3'd0, 32'd6, 32'd7, 5'd21, -1, -1, 1'b1, 32'd42);

    // Back-to-back divides with no idle gap.
    do_op(3'd5, 32'd81, 32'd9, 5'd22, -1, -1, 1'b1, 32'd9);
    do_op(3'd7, 32'd81, 32'd10, 5'd23, -1, -1, 1'b1, 32'd1);

    // Reset in the middle of a divide.
    do_op(3'd4, 32'd12345, 32'd17, 5'd24, -1, 5, 1'b0, 32'd0);
    idle(2);

    for (int n = 0; n < 150; n++) begin
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), -1, -1, 1'b0, 32'd0);
      idle($urandom_range(0, 2));
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
